// File: rtl/fp16_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_acc_pkg
//  Description : Shared constants and types for the FP16 group accumulator:
//                FP16 zero encoding, adder latency, in-flight counter width
//                and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package fp16_acc_pkg;

   localparam logic [15:0] FP16_ZERO  = 16'h0000;
   localparam int          ADD_LAT    = 5;
   localparam int          INFLIGHT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_accum_ctrl_add.sv
`default_nettype none
// ============================================================================
//  Module      : float16_add
//  Description : Pipelined FP16 adder, one operation per cycle, ADD_LAT
//                cycles from de_in to de_out. Round toward zero, exponent-0
//                operands read as zero, results below the normal range flush
//                to +0, results above exponent 31 saturate to exp 31/frac 1023.
//  Ports       : clk, rst_b (async active-low, clears the whole pipe)
//                de_in, a, b      operation valid and operands
//                de_out, data_out result valid and sum
//  Revision    : 1.0  initial release
// ============================================================================
module float16_add
   import fp16_acc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_b,
   input  logic        de_in,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        de_out,
   output logic [15:0] data_out
);

   // Stage 1: order by magnitude, align exactly, add or subtract.
   // The 42-bit alignment field holds any exponent difference (max 31)
   // without dropping bits, so the later truncation is exact round-to-zero.
   logic [10:0] a_man, b_man, big_man, small_man;
   logic [4:0]  big_exp, exp_diff;
   logic [41:0] big_al, small_al;
   logic        swap;
   logic        s1_valid_d, s1_valid_q;
   logic [42:0] s1_mag_d, s1_mag_q;
   logic [4:0]  s1_exp_d, s1_exp_q;
   logic        s1_sign_d, s1_sign_q;

   always_comb begin
      a_man     = (a[14:10] == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
      b_man     = (b[14:10] == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
      swap      = {a[14:10], a_man} < {b[14:10], b_man};
      big_man   = swap ? b_man : a_man;
      small_man = swap ? a_man : b_man;
      big_exp   = swap ? b[14:10] : a[14:10];
      exp_diff  = big_exp - (swap ? a[14:10] : b[14:10]);
      big_al    = {big_man, 31'd0};
      small_al  = {small_man, 31'd0} >> exp_diff;
      s1_valid_d = de_in;
      s1_exp_d   = big_exp;
      s1_sign_d  = swap ? b[15] : a[15];
      if (a[15] ^ b[15]) s1_mag_d = {1'b0, big_al} - {1'b0, small_al};
      else               s1_mag_d = {1'b0, big_al} + {1'b0, small_al};
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         s1_valid_q <= 1'b0;
         s1_mag_q   <= '0;
         s1_exp_q   <= '0;
         s1_sign_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_mag_q   <= s1_mag_d;
         s1_exp_q   <= s1_exp_d;
         s1_sign_q  <= s1_sign_d;
      end
   end

   // Stage 2: normalise and pack. The big operand's leading one sits at
   // bit 41, so the result exponent is big_exp + (lead - 41).
   logic [5:0]        lead;
   logic signed [7:0] exp_n;
   logic [9:0]        frac;
   logic [15:0]       res_d;

   always_comb begin
      lead = '0;
      for (int i = 0; i < 43; i++) begin
         if (s1_mag_q[i]) lead = 6'(i);
      end
      exp_n = $signed({3'b000, s1_exp_q}) + $signed({2'b00, lead}) - 8'sd41;
      frac  = 10'(s1_mag_q >> (lead - 6'd10));
      if (s1_mag_q == '0 || exp_n < 8'sd1) res_d = FP16_ZERO;
      else if (exp_n > 8'sd31)             res_d = {s1_sign_q, 5'h1F, 10'h3FF};
      else                                 res_d = {s1_sign_q, exp_n[4:0], frac};
   end

   // Stages 2..ADD_LAT: result register followed by a plain delay line.
   logic [ADD_LAT:2] vld_q;
   logic [15:0]      dat_q [2:ADD_LAT];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         vld_q <= '0;
         for (int i = 2; i <= ADD_LAT; i++) dat_q[i] <= FP16_ZERO;
      end else begin
         vld_q[2] <= s1_valid_q;
         dat_q[2] <= res_d;
         for (int i = 3; i <= ADD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign de_out   = vld_q[ADD_LAT];
   assign data_out = dat_q[ADD_LAT];

endmodule
`default_nettype wire

// File: rtl/fp16_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fp16_accum_ctrl
//  Description : Reduces a group of cfg_len FP16 values to one FP16 sum with a
//                single pipelined adder. Up to ADD_LAT partial sums circulate
//                through the adder while input arrives; a drain phase then
//                pairs returning partial sums until one remains.
//  Ports       : clk, rst_b (async active-low)
//                cfg_len   group length, sampled on the first accept (0 -> 1)
//                in_valid/in_ready/in_data  input stream
//                out_valid/out_data         one-cycle result pulse
//                busy      high whenever not idle
//  Revision    : 1.0  initial release
// ============================================================================
module fp16_accum_ctrl
   import fp16_acc_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   output logic             out_valid,
   output logic [15:0]      out_data,
   output logic             busy
);

   acc_state_t            state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
   logic [15:0]           hold_q, hold_d;
   logic                  hold_valid_q, hold_valid_d;

   logic                  accept;
   logic [LEN_W-1:0]      eff_len;
   logic                  de_in, de_out;
   logic [15:0]           add_a, add_b, add_out;

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
   assign accept    = in_valid && in_ready;
   assign eff_len   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = out_valid ? hold_q : FP16_ZERO;

   // A returning token is always recycled as operand A.
   assign add_a = de_out ? add_out : FP16_ZERO;

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      de_in        = 1'b0;
      add_b        = accept ? in_data : FP16_ZERO;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               de_in   = 1'b1;
               len_d   = eff_len;
               cnt_d   = LEN_W'(1);
               state_d = (eff_len == LEN_W'(1)) ? ST_DRAIN : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            // Issue on gap cycles too, so every returning token re-enters.
            de_in = 1'b1;
            if (accept) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q + LEN_W'(1) == len_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (de_out) begin
               if (hold_valid_q) begin
                  de_in        = 1'b1;
                  add_b        = hold_q;
                  hold_valid_d = 1'b0;
               end else begin
                  hold_d       = add_out;
                  hold_valid_d = 1'b1;
               end
            end else if (inflight_q == '0 && hold_valid_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            hold_valid_d = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      inflight_d = inflight_q + INFLIGHT_W'(de_in) - INFLIGHT_W'(de_out);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         inflight_q   <= '0;
         hold_q       <= FP16_ZERO;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         inflight_q   <= inflight_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   float16_add u_add (
      .clk      (clk),
      .rst_b    (rst_b),
      .de_in    (de_in),
      .a        (add_a),
      .b        (add_b),
      .de_out   (de_out),
      .data_out (add_out)
   );

endmodule
`default_nettype wire

// File: doc/fp16_accum_ctrl.md
# fp16_accum_ctrl

Sequencer that reduces a group of `cfg_len` FP16 values to a single FP16 sum. It uses one pipelined `float16_add` instance, which has 5-cycle latency and accepts one operation per cycle. It feeds the convolution MAC path and sits between the product stream and the output buffer. It hides the adder latency by circulating up to 5 partial sums through the pipe, then folds the partial sums in a drain phase.

## Interface
- `LEN_W`, default 8: width of `cfg_len`.
- Reset: `rst_b`, asynchronous, active-low. Clock: `clk`.
- `clk`  in  1  clock.
- `rst_b`  in  1  async active-low reset.
- `cfg_len`  in  LEN_W  group length N. Sampled on the first accept of a group. 0 is treated as 1.
- `in_valid`  in  1  input value valid.
- `in_ready`  out  1  block can accept input.
- `in_data`  in  16  FP16 operand (sign 1, exp 5, frac 10).
- `out_valid`  out  1  one-cycle pulse; sum valid.
- `out_data`  out  16  FP16 group sum.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- **Accept** means `in_valid && in_ready`. `in_ready` = 1 in IDLE and ACCUM, 0 in DRAIN and DONE.
- **Adder operands:**
  - A = adder output if `de_out`, else 16'h0000.
  - B = `in_data` if accept, else 16'h0000.
- **IDLE:**
  - `de_in` = 0.
  - On accept: latch `len`, issue `add(0, in_data)`, set `cnt` = 1.
  - Go to DRAIN if `len` == 1, else to ACCUM.
- **ACCUM:**
  - `de_in` = 1 every cycle, including gaps, which issue `add(token|0, 0)`, so tokens keep circulating.
  - On accept: `cnt`++. When `cnt`+1 == `len`, go to DRAIN.
- **In-flight count `inflight` (0..5):**
  - `inflight` += `de_in` − `de_out` each cycle.
  - Never exceeds 5, because a return coincides with every issue once the pipe is full.
- **DRAIN:**
  - `de_in` = 1 only when pairing.
  - On `de_out` with `hold_valid`: issue `add(hold, data_out)` and clear `hold_valid`.
  - On `de_out` without `hold_valid`: `hold` ← `data_out`, set `hold_valid`.
  - When `inflight` == 0, `hold_valid` = 1 and no `de_out`: go to DONE.
- **DONE:**
  - `out_valid` = 1 and `out_data` = `hold` for exactly one cycle.
  - Clear `hold_valid`, then go to IDLE.
- **Arithmetic:** all rounding and overflow behaviour is inherited from `float16_add` (truncation, saturation to exp 31/frac 1023, exp-0 treated as zero).
  - Summation order is interleaved, not sequential.
  - The reference model must reproduce this exact order, for example with a cycle model of the token carousel.
- **Reset:**
  - Any state returns to IDLE.
  - `inflight`, `cnt` and `hold_valid` are cleared.
  - Tokens inside the adder are discarded, because the same `rst_b` clears the adder.
  - No output pulse is produced for an aborted group.

## Timing
- **Reset values:**
  - `in_ready` = 1 (IDLE).
  - `out_valid` = 0, `out_data` = 16'h0000, `busy` = 0.
- **Latency:** first accept at cycle 0 with N ≥ 5 accepted back-to-back gives `out_valid` at cycle N+18.
  - N = 1 gives `out_valid` at cycle 7.
- Input gaps lengthen latency. Worst case is bounded by last accept + 23 cycles.
- **Group turnaround:** a new group is accepted no earlier than the cycle after DONE.
- `in_ready` drops in the cycle after the accept that completes the group.
- A new `cfg_len` value has no effect until the next IDLE accept.

## Structure
- **Package `fp16_acc_pkg`:**
  - `FP16_ZERO` = 16'h0000.
  - `ADD_LAT` = 5.
  - `INFLIGHT_W` = 3.
  - State enum `acc_state_t`.
- **Sub-module:** one `float16_add` instance, owned by this block. Its `de_in` and `de_out` are used as the token valids.
- Estimated size: ~200 lines of RTL.

## Test plan
- N=4, 4× 16'h3C00 (1.0) back-to-back → one `out_valid` pulse, `out_data` = 16'h4400 (4.0).
- N=8, 8× 16'h3C00 back-to-back → `out_data` = 16'h4800 (8.0), `out_valid` at cycle 26.
- N=2, inputs 16'h4000 (2.0) then 16'hBC00 (−1.0) with 3 idle cycles between them → `out_data` = 16'h3C00. `in_ready` = 1 during the gap.
- N=1, 16'h4200 (3.0) → `out_data` = 16'h4200 at cycle 7. `in_ready` = 0 in cycles 1–7.
- N=6, six values of 16'h3800 (0.5), `rst_b` pulsed low after 3 accepts → no `out_valid`, `busy` = 0, `in_ready` = 1. A following N=2 group of 1.0 + 1.0 gives 16'h4000.
- Overflow: N=2, 16'h7BFF + 16'h7BFF → `out_data` = 16'h7FFF (saturated).
